fifo_tx_serializer: RTL and testbench

Drains WIDTH-bit words from an upstream FIFO and transmits each word as a serial LSB-first frame onto the 1-bit system bus data line.
- Per frame: requests the bus from the arbiter, pops one word on grant, then shifts bits out under a per-bit valid/ready handshake.
- An optional even-parity bit is appended to each frame.
- Sits between a FIFO instance (read side) and the bus arbiter/slave port; the parent module instantiates and wires both.

---
 rtl/fifo_tx_pkg.sv | 19 +
 rtl/fifo_tx_serializer.sv | 152 +++++++++++++++
 tb/tb_fifo_tx_serializer.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_tx_pkg.sv
// Shared types and helpers for the FIFO-to-serial transmitter.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package fifo_tx_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        SHIFT  = 2'd2,
        PARITY = 2'd3
    } tx_state_t;

    // Bit-position counter width for a given word width.
    // $clog2(width) bits cover positions 0..width-1, with a floor of one bit.
    function automatic int bit_cnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/fifo_tx_serializer.sv
// Pops one FIFO word per bus grant and sends it LSB-first as a serial frame, with optional even parity.
// Latency: 1 cycle IDLE + 1 cycle REQ + WIDTH data cycles (+1 parity cycle); bus_req drops for one IDLE cycle between frames.
// Backpressure: tx_ready=0 or a lost grant stalls the frame in place, holding tx_data/tx_last and the bit position.
//
// Ports:
//   clk, rst                  rising-edge clock, synchronous active-high reset
//   fifo_empty, fifo_data     FIFO read side: empty flag and head word
//   fifo_deq                  one-cycle pop strobe, issued on the grant cycle in REQ
//   bus_req, bus_grant        arbiter handshake, request held for the whole frame
//   tx_data, tx_valid,        serial bit, bit valid (follows grant), last-bit marker
//   tx_last, tx_ready         and receiver accept
//   busy                      high whenever not IDLE
//   words_sent                completed-frame counter, wraps
module fifo_tx_serializer
    import fifo_tx_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int PARITY_EN = 1,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] fifo_data,
    output logic             fifo_deq,
    output logic             bus_req,
    input  logic             bus_grant,
    output logic             tx_data,
    output logic             tx_valid,
    output logic             tx_last,
    input  logic             tx_ready,
    output logic             busy,
    output logic [CNT_W-1:0] words_sent
);

    localparam int                   BIT_CNT_W = bit_cnt_width(WIDTH);
    localparam logic [BIT_CNT_W-1:0] LAST_BIT  = BIT_CNT_W'(WIDTH - 1);
    localparam bit                   PAR_ON    = (PARITY_EN != 0);

    tx_state_t            state;
    tx_state_t            state_nxt;
    logic [WIDTH-1:0]     shift_reg;
    logic [BIT_CNT_W-1:0] bit_cnt;
    logic                 parity;

    logic                 load;        // grant cycle: capture the FIFO head
    logic                 xfer;        // a data bit is accepted this cycle
    logic                 frame_done;  // final bit of the frame is accepted
    logic                 last_bit;

    assign last_bit = (bit_cnt == LAST_BIT);
    assign busy     = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        load       = 1'b0;
        xfer       = 1'b0;
        frame_done = 1'b0;
        fifo_deq   = 1'b0;
        bus_req    = 1'b0;
        tx_data    = 1'b0;
        tx_valid   = 1'b0;
        tx_last    = 1'b0;

        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    state_nxt = REQ;
                end
            end

            REQ: begin
                bus_req = 1'b1;
                // A vanished head word means another reader touched the FIFO;
                // back off without popping rather than load garbage.
                if (fifo_empty) begin
                    state_nxt = IDLE;
                end else if (bus_grant) begin
                    fifo_deq  = 1'b1;
                    load      = 1'b1;
                    state_nxt = SHIFT;
                end
            end

            SHIFT: begin
                bus_req  = 1'b1;
                tx_data  = shift_reg[0];
                tx_valid = bus_grant;
                // Without a parity bit the last data bit closes the frame.
                tx_last  = !PAR_ON && last_bit;
                if (bus_grant && tx_ready) begin
                    xfer = 1'b1;
                    if (last_bit) begin
                        if (PAR_ON) begin
                            state_nxt = PARITY;
                        end else begin
                            state_nxt  = IDLE;
                            frame_done = 1'b1;
                        end
                    end
                end
            end

            PARITY: begin
                bus_req  = 1'b1;
                tx_data  = parity;
                tx_valid = bus_grant;
                tx_last  = 1'b1;
                if (bus_grant && tx_ready) begin
                    state_nxt  = IDLE;
                    frame_done = 1'b1;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Datapath only moves on load or accepted bit, so stalls hold everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_reg  <= '0;
            bit_cnt    <= '0;
            parity     <= 1'b0;
            words_sent <= '0;
        end else begin
            if (load) begin
                shift_reg <= fifo_data;
                bit_cnt   <= '0;
                parity    <= 1'b0;
            end else if (xfer) begin
                shift_reg <= {1'b0, shift_reg[WIDTH-1:1]};
                bit_cnt   <= bit_cnt + BIT_CNT_W'(1);
                parity    <= parity ^ shift_reg[0];
            end
            if (frame_done) begin
                words_sent <= words_sent + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_fifo_tx_serializer.sv
// Directed bench: dut_a is 8-bit with parity, dut_b is 8-bit without parity and a 2-bit counter.
// Latency: n/a (testbench).
// Backpressure: tx_ready/bus_grant patterns are driven per cycle by the frame runner.
module tb_fifo_tx_serializer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       tx_ready;
    logic       bus_grant;

    logic       a_rst, a_fifo_empty, a_fifo_deq, a_bus_req;
    logic       a_tx_data, a_tx_valid, a_tx_last, a_busy;
    logic [7:0] a_fifo_data;
    logic [15:0] a_words_sent;

    logic       b_rst, b_fifo_empty, b_fifo_deq, b_bus_req;
    logic       b_tx_data, b_tx_valid, b_tx_last, b_busy;
    logic [7:0] b_fifo_data;
    logic [1:0] b_words_sent;

    fifo_tx_serializer #(.WIDTH(8), .PARITY_EN(1), .CNT_W(16)) dut_a (
        .clk(clk), .rst(a_rst),
        .fifo_empty(a_fifo_empty), .fifo_data(a_fifo_data), .fifo_deq(a_fifo_deq),
        .bus_req(a_bus_req), .bus_grant(bus_grant),
        .tx_data(a_tx_data), .tx_valid(a_tx_valid), .tx_last(a_tx_last), .tx_ready(tx_ready),
        .busy(a_busy), .words_sent(a_words_sent)
    );

    fifo_tx_serializer #(.WIDTH(8), .PARITY_EN(0), .CNT_W(2)) dut_b (
        .clk(clk), .rst(b_rst),
        .fifo_empty(b_fifo_empty), .fifo_data(b_fifo_data), .fifo_deq(b_fifo_deq),
        .bus_req(b_bus_req), .bus_grant(bus_grant),
        .tx_data(b_tx_data), .tx_valid(b_tx_valid), .tx_last(b_tx_last), .tx_ready(tx_ready),
        .busy(b_busy), .words_sent(b_words_sent)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] qa[$];
    logic [7:0] qb[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic refresh();
        a_fifo_empty = (qa.size() == 0);
        a_fifo_data  = (qa.size() != 0) ? qa[0] : 8'h00;
        b_fifo_empty = (qb.size() == 0);
        b_fifo_data  = (qb.size() != 0) ? qb[0] : 8'h00;
    endtask

    // Advance one clock; the FIFO model pops on a strobe seen before the edge.
    task automatic step();
        logic da, db;
        da = a_fifo_deq;
        db = b_fifo_deq;
        @(posedge clk);
        #1;
        if (da === 1'b1 && qa.size() != 0) void'(qa.pop_front());
        if (db === 1'b1 && qb.size() != 0) void'(qb.pop_front());
        refresh();
    endtask

    // Runs one frame from the IDLE cycle until busy falls again.
    // stall_k*/gap_k name the bit index before which ready/grant are dropped; abort_k
    // pulses reset when that many bits have been sent. Negative values disable them.
    task automatic run_frame(input bit sel,
                             input int stall_k1, input int stall_k2, input int stall_len,
                             input int gap_k, input int gap_len, input int abort_k,
                             output int cycles, output logic [15:0] bits, output int nbits,
                             output int ndeq, output int last_pos, output int nlast,
                             output int req_cyc, output int bad, output bit done);
        int   stall_left, gap_left;
        bit   s1, s2, g, seen_busy;
        logic hd, hl;
        logic o_deq, o_req, o_dat, o_vld, o_last, o_busy, o_empty;
        stall_left = 0; gap_left = 0; s1 = 0; s2 = 0; g = 0; seen_busy = 0;
        hd = 0; hl = 0;
        cycles = 0; bits = '0; nbits = 0; ndeq = 0; last_pos = -1; nlast = 0;
        req_cyc = -1; bad = 0; done = 0;
        for (int c = 0; c < 100; c++) begin
            if (ndeq > 0 && stall_left == 0 && !s1 && nbits == stall_k1) begin
                stall_left = stall_len; s1 = 1;
            end else if (ndeq > 0 && stall_left == 0 && !s2 && nbits == stall_k2) begin
                stall_left = stall_len; s2 = 1;
            end
            if (ndeq > 0 && gap_left == 0 && !g && nbits == gap_k) begin
                gap_left = gap_len; g = 1;
            end
            tx_ready  = (stall_left == 0);
            bus_grant = (gap_left == 0);
            if (ndeq > 0 && nbits == abort_k) begin
                if (sel) b_rst = 1'b1; else a_rst = 1'b1;
                step();
                a_rst = 1'b0;
                b_rst = 1'b0;
                #1;
                cycles = c;
                done   = 1;
                return;
            end
            #1;
            if (sel) {o_deq, o_req, o_dat, o_vld, o_last, o_busy, o_empty} =
                         {b_fifo_deq, b_bus_req, b_tx_data, b_tx_valid, b_tx_last, b_busy, b_fifo_empty};
            else     {o_deq, o_req, o_dat, o_vld, o_last, o_busy, o_empty} =
                         {a_fifo_deq, a_bus_req, a_tx_data, a_tx_valid, a_tx_last, a_busy, a_fifo_empty};
            if (o_busy) begin
                seen_busy = 1;
            end else if (seen_busy) begin
                cycles = c;
                done   = 1;
                return;
            end
            if (o_req && req_cyc < 0) req_cyc = c;
            if (o_deq) begin
                ndeq++;
                if (o_empty) bad++;
            end
            if (stall_left > 0) begin
                if (stall_left == stall_len) begin
                    hd = o_dat; hl = o_last;
                end else if (o_dat !== hd || o_last !== hl) begin
                    bad++;
                end
                if (!o_vld) bad++;
                stall_left--;
            end
            if (gap_left > 0) begin
                if (o_vld || !o_req) bad++;
                gap_left--;
            end
            if (o_vld && tx_ready) begin
                bits[nbits] = o_dat;
                if (o_last) begin
                    nlast++;
                    last_pos = nbits;
                end
                nbits++;
            end
            step();
        end
    endtask

    int          cyc, nb, nd, lp, nl, rc, bd;
    int          deq_total;
    logic [15:0] bv;
    bit          ok;
    logic [7:0]  bw [5];
    logic [1:0]  bcnt [5];

    initial begin
        tx_ready = 0; bus_grant = 0;
        a_rst = 1; b_rst = 1;
        refresh();
        step();
        step();
        a_rst = 0; b_rst = 0;
        #1;
        chk("rst_busy",   a_busy, 0);
        chk("rst_req",    a_bus_req, 0);
        chk("rst_valid",  a_tx_valid, 0);
        chk("rst_last",   a_tx_last, 0);
        chk("rst_data",   a_tx_data, 0);
        chk("rst_deq",    a_fifo_deq, 0);
        chk("rst_cnt_a",  a_words_sent, 0);
        chk("rst_cnt_b",  b_words_sent, 0);

        // Basic frame 8'hA5: 1,0,1,0,0,1,0,1 then parity 0.
        qa.push_back(8'hA5); refresh();
        run_frame(0, -1, -1, 0, -1, 0, -1, cyc, bv, nb, nd, lp, nl, rc, bd, ok);
        chk("a5_done",    ok, 1);
        chk("a5_cycles",  cyc, 11);
        chk("a5_req_rise", rc, 1);
        chk("a5_deq",     nd, 1);
        chk("a5_bits",    bv, 16'h00A5);
        chk("a5_nbits",   nb, 9);
        chk("a5_lastpos", lp, 8);
        chk("a5_nlast",   nl, 1);
        chk("a5_proto",   bd, 0);
        chk("a5_cnt",     a_words_sent, 1);
        chk("a5_req_gap", a_bus_req, 0);

        // Ready stalls of 3 cycles before bits 2 and 5.
        qa.push_back(8'hA5); refresh();
        run_frame(0, 2, 5, 3, -1, 0, -1, cyc, bv, nb, nd, lp, nl, rc, bd, ok);
        chk("stall_done",   ok, 1);
        chk("stall_cycles", cyc, 17);
        chk("stall_bits",   bv, 16'h00A5);
        chk("stall_hold",   bd, 0);
        chk("stall_last",   lp, 8);
        chk("stall_cnt",    a_words_sent, 2);

        // Grant lost for 4 cycles after bit 3 of 8'h3C.
        qa.push_back(8'h3C); refresh();
        run_frame(0, -1, -1, 0, 4, 4, -1, cyc, bv, nb, nd, lp, nl, rc, bd, ok);
        chk("gap_done",   ok, 1);
        chk("gap_cycles", cyc, 15);
        chk("gap_bits",   bv, 16'h003C);
        chk("gap_bit4",   bv[4], 1);
        chk("gap_proto",  bd, 0);
        chk("gap_cnt",    a_words_sent, 3);

        // Reset after bit 4 of 8'hF0; 8'h57 then goes out whole, parity 1.
        qa.push_back(8'hF0); qa.push_back(8'h57); refresh();
        run_frame(0, -1, -1, 0, -1, 0, 5, cyc, bv, nb, nd, lp, nl, rc, bd, ok);
        chk("abort_done",  ok, 1);
        chk("abort_busy",  a_busy, 0);
        chk("abort_req",   a_bus_req, 0);
        chk("abort_valid", a_tx_valid, 0);
        chk("abort_last",  a_tx_last, 0);
        chk("abort_data",  a_tx_data, 0);
        chk("abort_deq",   a_fifo_deq, 0);
        chk("abort_cnt",   a_words_sent, 0);
        chk("abort_qlen",  qa.size(), 1);
        run_frame(0, -1, -1, 0, -1, 0, -1, cyc, bv, nb, nd, lp, nl, rc, bd, ok);
        chk("resume_done", ok, 1);
        chk("resume_bits", bv, 16'h0157);
        chk("resume_deq",  nd, 1);
        chk("resume_cnt",  a_words_sent, 1);

        // No-parity DUT: five back-to-back words, 2-bit counter wraps.
        bw   = '{8'h01, 8'hFF, 8'h80, 8'h3C, 8'hA5};
        bcnt = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        for (int i = 0; i < 5; i++) qb.push_back(bw[i]);
        refresh();
        deq_total = 0;
        for (int i = 0; i < 5; i++) begin
            run_frame(1, -1, -1, 0, -1, 0, -1, cyc, bv, nb, nd, lp, nl, rc, bd, ok);
            deq_total += nd;
            chk($sformatf("b%0d_done", i),    ok, 1);
            chk($sformatf("b%0d_cycles", i),  cyc, 10);
            chk($sformatf("b%0d_bits", i),    bv, {8'h00, bw[i]});
            chk($sformatf("b%0d_nbits", i),   nb, 8);
            chk($sformatf("b%0d_lastpos", i), lp, 7);
            chk($sformatf("b%0d_nlast", i),   nl, 1);
            chk($sformatf("b%0d_proto", i),   bd, 0);
            chk($sformatf("b%0d_reqlow", i),  b_bus_req, 0);
            chk($sformatf("b%0d_cnt", i),     b_words_sent, bcnt[i]);
            if (i == 2) begin
                chk("b_deq_total3", deq_total, 3);
                chk("b_qlen3",      qb.size(), 2);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
